// File: rtl/ifid_branch_alu.sv
// IF/ID pipeline register with stall/flush, decode-stage branch-target adder
// and execute-stage integer ALU for the 5-stage MIPS pipeline.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset of the IF/ID register
//   en           IF/ID load enable (0 = hold, stall)
//   clr          synchronous IF/ID flush, wins over en
//   rd           fetched instruction word
//   pc_plus_f    fetch-stage PC+1
//   instr_d      decode-stage instruction
//   pc_plus_d    decode-stage PC+1
//   sign_imm_d   sign-extended immediate of instr_d
//   pc_branch_d  branch target, pc_plus_d + sign_imm_d (word-indexed PC)
//   alu_control  ALU operation select
//   src_a        ALU operand A
//   src_b        ALU operand B
//   alu_result   ALU result
//   zero         1 when alu_result is all zeros
module ifid_branch_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] rd,
    input  logic [WIDTH-1:0] pc_plus_f,
    output logic [WIDTH-1:0] instr_d,
    output logic [WIDTH-1:0] pc_plus_d,
    input  logic [WIDTH-1:0] sign_imm_d,
    output logic [WIDTH-1:0] pc_branch_d,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero
);

    logic             sltBit;
    logic [WIDTH-1:0] aluNext;

    // A cleared register reads as sll $0,$0,0, i.e. a NOP in decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_d   <= '0;
            pc_plus_d <= '0;
        end else if (clr) begin
            instr_d   <= '0;
            pc_plus_d <= '0;
        end else if (en) begin
            instr_d   <= rd;
            pc_plus_d <= pc_plus_f;
        end
    end

    // PC counts words, so the immediate is added without a shift.
    assign pc_branch_d = pc_plus_d + sign_imm_d;

    // A direct signed compare stays correct when A - B overflows.
    assign sltBit = $signed(src_a) < $signed(src_b);

    always_comb begin
        aluNext = '0;
        unique case (alu_control)
            3'b000: aluNext = src_a & src_b;
            3'b001: aluNext = src_a | src_b;
            3'b010: aluNext = src_a + src_b;
            3'b011: aluNext = '0;
            3'b100: aluNext = src_a & ~src_b;
            3'b101: aluNext = src_a | ~src_b;
            3'b110: aluNext = src_a - src_b;
            3'b111: aluNext = {{(WIDTH-1){1'b0}}, sltBit};
            default: aluNext = '0;
        endcase
    end

    assign alu_result = aluNext;
    assign zero       = (aluNext == '0);

endmodule

// File: tb/tb_ifid_branch_alu.sv
// Directed-vector bench for ifid_branch_alu: IF/ID register, branch adder
// and ALU, each exercised by its own scenario task.
module tb_ifid_branch_alu;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         en;
    logic         clr;
    logic [W-1:0] rd;
    logic [W-1:0] pcPlusF;
    logic [W-1:0] instrD;
    logic [W-1:0] pcPlusD;
    logic [W-1:0] signImmD;
    logic [W-1:0] pcBranchD;
    logic [2:0]   aluControl;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic [W-1:0] aluResult;
    logic         zero;

    int vecs = 0;
    int errs = 0;

    ifid_branch_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .clr         (clr),
        .rd          (rd),
        .pc_plus_f   (pcPlusF),
        .instr_d     (instrD),
        .pc_plus_d   (pcPlusD),
        .sign_imm_d  (signImmD),
        .pc_branch_d (pcBranchD),
        .alu_control (aluControl),
        .src_a       (srcA),
        .src_b       (srcB),
        .alu_result  (aluResult),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0;
        en = 1'b1;
        clr = 1'b0;
        rd = 32'h8C220004;
        pcPlusF = 32'd5;
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if (instrD !== 32'h0 || pcPlusD !== 32'h0) begin
            errs++;
            $display("FAIL reset_hold: instr=%h pc=%h want 0 0", instrD, pcPlusD);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        vecs++;
        if (instrD !== 32'h8C220004 || pcPlusD !== 32'd5) begin
            errs++;
            $display("FAIL first_load: instr=%h pc=%h want 8c220004 5",
                     instrD, pcPlusD);
        end
        #2;
        reset = 1'b0;
        #1;
        vecs++;
        if (instrD !== 32'h0 || pcPlusD !== 32'h0) begin
            errs++;
            $display("FAIL async_reset: instr=%h pc=%h want 0 0", instrD, pcPlusD);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        vecs++;
        if (instrD !== 32'h8C220004 || pcPlusD !== 32'd5) begin
            errs++;
            $display("FAIL reload: instr=%h pc=%h want 8c220004 5",
                     instrD, pcPlusD);
        end
    endtask

    task automatic test_stall_flush();
        @(negedge clk);
        en = 1'b0;
        rd = 32'hAC020008;
        pcPlusF = 32'd9;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vecs++;
            if (instrD !== 32'h8C220004 || pcPlusD !== 32'd5) begin
                errs++;
                $display("FAIL stall_%0d: instr=%h pc=%h want 8c220004 5",
                         i, instrD, pcPlusD);
            end
        end
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        vecs++;
        if (instrD !== 32'h0 || pcPlusD !== 32'h0) begin
            errs++;
            $display("FAIL flush_in_stall: instr=%h pc=%h want 0 0",
                     instrD, pcPlusD);
        end
        @(negedge clk);
        clr = 1'b1;
        en = 1'b1;
        @(posedge clk);
        #1;
        vecs++;
        if (instrD !== 32'h0 || pcPlusD !== 32'h0) begin
            errs++;
            $display("FAIL flush_over_en: instr=%h pc=%h want 0 0",
                     instrD, pcPlusD);
        end
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_branch();
        @(negedge clk);
        en = 1'b1;
        pcPlusF = 32'h10;
        signImmD = 32'h4;
        @(posedge clk);
        #1;
        vecs++;
        if (pcBranchD !== 32'h14) begin
            errs++;
            $display("FAIL br_fwd: got %h want 00000014", pcBranchD);
        end
        signImmD = 32'hFFFFFFFC;
        #1;
        vecs++;
        if (pcBranchD !== 32'h0C) begin
            errs++;
            $display("FAIL br_back: got %h want 0000000c", pcBranchD);
        end
        @(negedge clk);
        pcPlusF = 32'hFFFFFFFF;
        signImmD = 32'h1;
        @(posedge clk);
        #1;
        vecs++;
        if (pcBranchD !== 32'h0) begin
            errs++;
            $display("FAIL br_wrap: got %h want 00000000", pcBranchD);
        end
    endtask

    task automatic test_alu_logic();
        logic [2:0]   ops[7];
        logic [W-1:0] exp[7];
        ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b100, 3'b101, 3'b011};
        exp = '{32'h5, 32'hF, 32'h14, 32'hA, 32'hA, 32'hFFFFFFFF, 32'h0};
        srcA = 32'h0000000F;
        srcB = 32'h00000005;
        for (int i = 0; i < 7; i++) begin
            aluControl = ops[i];
            #1;
            vecs++;
            if (aluResult !== exp[i] || zero !== (exp[i] == 0)) begin
                errs++;
                $display("FAIL alu_op%b: got %h z=%b want %h z=%b",
                         ops[i], aluResult, zero, exp[i], exp[i] == 0);
            end
        end
    endtask

    task automatic test_slt();
        logic [W-1:0] a[4];
        logic [W-1:0] b[4];
        logic [W-1:0] exp[4];
        a = '{32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h7};
        b = '{32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h7};
        exp = '{32'h1, 32'h0, 32'h1, 32'h0};
        aluControl = 3'b111;
        for (int i = 0; i < 4; i++) begin
            srcA = a[i];
            srcB = b[i];
            #1;
            vecs++;
            if (aluResult !== exp[i] || zero !== (exp[i] == 0)) begin
                errs++;
                $display("FAIL slt_%0d: got %h z=%b want %h z=%b",
                         i, aluResult, zero, exp[i], exp[i] == 0);
            end
        end
    endtask

    task automatic test_sub_wrap();
        aluControl = 3'b110;
        srcA = 32'h0;
        srcB = 32'h1;
        #1;
        vecs++;
        if (aluResult !== 32'hFFFFFFFF || zero !== 1'b0) begin
            errs++;
            $display("FAIL sub_wrap: got %h z=%b want ffffffff z=0",
                     aluResult, zero);
        end
        srcA = 32'h1234;
        srcB = 32'h1234;
        #1;
        vecs++;
        if (aluResult !== 32'h0 || zero !== 1'b1) begin
            errs++;
            $display("FAIL sub_equal: got %h z=%b want 00000000 z=1",
                     aluResult, zero);
        end
    endtask

    initial begin
        reset = 1'b0;
        en = 1'b0;
        clr = 1'b0;
        rd = '0;
        pcPlusF = '0;
        signImmD = '0;
        aluControl = 3'b000;
        srcA = '0;
        srcB = '0;
        test_reset();
        test_stall_flush();
        test_branch();
        test_alu_logic();
        test_slt();
        test_sub_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ifid_branch_alu.md
Name: ifid_branch_alu

Overview:
- Combines the fetch/decode pipeline register, the decode-stage branch-target adder and the execute-stage integer ALU of the 5-stage MIPS pipeline.
- The register captures the fetched instruction and PC+1 into decode. It supports stall (enable low) and flush (synchronous clear).
- The adder forms the branch target from the registered PC+1 and the sign-extended immediate.
- The ALU is purely combinational and is driven by the execute-stage operand muxes.

Parameters:
- WIDTH, 32, datapath width for instruction, PC, immediate, ALU operands and result

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset of the IF/ID register
- en  in  1  IF/ID load enable (driven by ~StallD); 0 = hold
- clr  in  1  synchronous IF/ID flush (jump or taken branch)
- rd  in  WIDTH  instruction word from instruction memory (fetch stage)
- pc_plus_f  in  WIDTH  fetch-stage PC+1
- instr_d  out  WIDTH  registered instruction, decode stage
- pc_plus_d  out  WIDTH  registered PC+1, decode stage
- sign_imm_d  in  WIDTH  sign-extended immediate of instr_d (external sign extender)
- pc_branch_d  out  WIDTH  branch target = sign_imm_d + pc_plus_d
- alu_control  in  3  ALU operation select
- src_a  in  WIDTH  ALU operand A
- src_b  in  WIDTH  ALU operand B
- alu_result  out  WIDTH  ALU result
- zero  out  1  1 when alu_result == 0

Behaviour:
- IF/ID register (instr_d, pc_plus_d):
  - reset low: both outputs go to 0 immediately, independent of clk. While reset is low they stay 0.
  - On each rising clk edge with reset high, the first matching rule applies: clr=1 loads 0 into both, which yields a NOP (sll $0,$0,0); else en=1 loads rd and pc_plus_f; else (en=0) both hold.
  - clr has priority over en, so a flush during a stall still clears.
  - Latency is 1 cycle from rd/pc_plus_f to instr_d/pc_plus_d.
  - Reset release is synchronised by the system; the first edge after release follows the normal rules.
- Branch adder:
  - Combinational: pc_branch_d = (pc_plus_d + sign_imm_d) mod 2^WIDTH.
  - No shift, because the PC is word-indexed. No carry or overflow output.
- ALU is combinational, with no overflow detection or traps. Operations by alu_control:
  - 000: A & B
  - 001: A | B
  - 010: A + B, wrapping mod 2^WIDTH
  - 011: result 0 (reserved)
  - 100: A & ~B
  - 101: A | ~B
  - 110: A - B, wrapping
  - 111: SLT. Result is 1 if signed A < signed B, else 0. Comparison is two's-complement, correct even when A - B overflows.
- zero is derived from alu_result for every opcode.
- Outputs carry no X after reset; all operations are defined for all input values.

Test Plan:
- Reset and load: hold reset=0 with rd=0x8C220004 and pc_plus_f=5, so instr_d=0 and pc_plus_d=0. Then set reset=1, en=1, clr=0; after one edge, instr_d=0x8C220004 and pc_plus_d=5. Asserting reset=0 mid-cycle zeroes both before the next edge.
- Stall then flush: with instr_d=0x8C220004 loaded, set en=0 and change rd=0xAC020008; the register holds 0x8C220004 over 3 edges. Then set clr=1 with en=0; after one edge instr_d=0 and pc_plus_d=0.
- Branch target:
  - pc_plus_d=0x10, sign_imm_d=0x00000004 gives pc_branch_d=0x14.
  - sign_imm_d=0xFFFFFFFC gives 0x0C.
  - pc_plus_d=0xFFFFFFFF with sign_imm_d=1 gives 0 (wrap).
- ALU logic and arithmetic with A=0x0000000F, B=0x00000005:
  - 000 gives 0x5; 001 gives 0xF; 010 gives 0x14; 110 gives 0xA.
  - 100 gives 0xA; 101 gives 0xFFFFFFFF; 011 gives 0 with zero=1.
- SLT signed:
  - A=0xFFFFFFFF (-1), B=1 gives 1.
  - A=1, B=0xFFFFFFFF gives 0.
  - A=0x80000000, B=0x7FFFFFFF gives 1 (overflow case).
  - A=B=7 gives 0 with zero=1.
- Sub wrap: A=0, B=1, op 110 gives 0xFFFFFFFF with zero=0. A=B=0x1234, op 110 gives 0 with zero=1.
